// File: rtl/spi_slave.sv
// spi_slave: byte-oriented SPI mode-0 slave, oversampled on clk, RX bytes on a valid/ready stream.
// Define SPI_SLAVE_RX_FIFO_EN to replace the single RX output register with a FIFO_DEPTH-entry FIFO.
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              busy
);

  if (DATA_W < 2 || SYNC_STAGES < 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("spi_slave: need DATA_W >= 2, SYNC_STAGES >= 2, FIFO_DEPTH a power of two >= 2");
  end

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_COMPLETE,
    S_WAIT
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic                   ss_dly_q, ss_dly_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]      tx_hold_q, tx_hold_d;
  logic                   tx_ready_q, tx_ready_d;
  logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;

  logic sclk_s, mosi_s, ss_s;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic frame_start, push, overrun_set;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s &  sclk_dly_q;
  assign ss_rise   =  ss_s   & ~ss_dly_q;
  assign ss_fall   = ~ss_s   &  ss_dly_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    sclk_dly_d  = sclk_s;
    ss_dly_d    = ss_s;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    tx_hold_d   = tx_hold_q;
    tx_ready_d  = tx_ready_q;
    rx_shift_d  = rx_shift_q;
    busy_d      = busy_q;
    frame_start = 1'b0;
    push        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ss_fall) begin
          frame_start = 1'b1;
          tx_shift_d  = tx_hold_q;
          tx_hold_d   = '0;
          tx_ready_d  = 1'b1;
          bit_cnt_d   = '0;
          busy_d      = 1'b1;
          state_d     = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (ss_rise) begin
          // Aborted frame: the partial RX byte is simply never pushed.
          tx_shift_d = '0;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
              state_d = S_COMPLETE;
            end
          end
          if (sclk_fall) begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      S_COMPLETE: begin
        push = 1'b1;
        if (ss_rise) begin
          tx_shift_d = '0;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ss_rise) begin
          tx_shift_d = '0;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A load coinciding with the frame-start copy lands in the freshly emptied holding register.
    if (tx_load && (tx_ready_q || frame_start)) begin
      tx_hold_d  = tx_data;
      tx_ready_d = 1'b0;
    end

    overrun_d = overrun_q | overrun_set;
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking is reserved for always_comb.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      // ss resets low so a select already asserted at reset release cannot look like a falling edge.
      ss_sync_q   <= '0;
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b0;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      tx_hold_q   <= '0;
      tx_ready_q  <= 1'b1;
      rx_shift_q  <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      ss_dly_q    <= ss_dly_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      tx_hold_q   <= tx_hold_d;
      tx_ready_q  <= tx_ready_d;
      rx_shift_q  <= rx_shift_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign miso     = tx_shift_q[DATA_W-1];
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              fifo_empty, fifo_full, pop, wr_en;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop        = rx_ready & ~fifo_empty;

  always_comb begin
    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    wr_en       = push & (~fifo_full | pop);
    overrun_set = push & fifo_full & ~pop;
    wr_ptr_d    = wr_ptr_q + {{PTR_W{1'b0}}, wr_en};
    rd_ptr_d    = rd_ptr_q + {{PTR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= rx_shift_q;
    end
  end

  assign rx_valid = ~fifo_empty;
  assign rx_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_q[PTR_W-1:0]];
`else
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;

  always_comb begin
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_set = 1'b0;
    if (push) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_set = 1'b1;
      end
    end else if (rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI mode-0 master stimulus with a scoreboard of expected RX bytes.
// Build with SPI_SLAVE_RX_FIFO_EN defined to exercise the FIFO configuration.
module tb_spi_slave;

  localparam int PH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk, mosi, ss, miso;
  logic [7:0] tx_data;
  logic       tx_load, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, overrun, busy;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];
  logic [7:0] miso_byte;
  logic       busy_mid, tx_ready_mid;

  spi_slave #(
    .DATA_W     (8),
    .SYNC_STAGES(2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sclk    (sclk),
    .mosi    (mosi),
    .ss      (ss),
    .miso    (miso),
    .tx_data (tx_data),
    .tx_load (tx_load),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_miso"},     miso,     1'b0);
    check({tag, "_tx_ready"}, tx_ready, 1'b1);
    check({tag, "_rx_data"},  rx_data,  8'h00);
    check({tag, "_rx_valid"}, rx_valid, 1'b0);
    check({tag, "_overrun"},  overrun,  1'b0);
    check({tag, "_busy"},     busy,     1'b0);
  endtask

  task automatic load_tx(input logic [7:0] v);
    tx_data = v;
    tx_load = 1'b1;
    tick(1);
    tx_load = 1'b0;
  endtask

  // Mode-0 master: data set while sclk low, sampled on rise; each phase lasts PH clk periods.
  task automatic spi_frame(input logic [7:0] tx_byte, input int nbits,
                           input bit end_frame, input bit pop_at_push);
    logic [7:0] head;
    miso_byte = '0;
    ss        = 1'b0;
    mosi      = tx_byte[7];
    tick(PH);
    for (int i = 0; i < nbits; i++) begin
      miso_byte[7-i] = miso;
      sclk = 1'b1;
      if (i == 1) begin
        busy_mid     = busy;
        tx_ready_mid = tx_ready;
      end
      if (pop_at_push && i == nbits - 1) begin
        // Land rx_ready on exactly the clk edge that registers the COMPLETE push.
        tick(PH - 1);
        head = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        check("full_pop_head", rx_data, head);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
      end else begin
        tick(PH);
      end
      sclk = 1'b0;
      if (i < nbits - 1) mosi = tx_byte[6-i];
      tick(PH);
    end
    if (end_frame) begin
      ss = 1'b1;
      tick(6);
    end
  endtask

  task automatic drain_one(input string tag);
    logic [7:0] exp;
    int         n;
    n = 0;
    while (rx_valid !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check({tag, "_valid"}, rx_valid, 1'b1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    check(tag, rx_data, exp);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    sclk         = 1'b0;
    mosi         = 1'b0;
    ss           = 1'b1;
    tx_data      = '0;
    tx_load      = 1'b0;
    rx_ready     = 1'b0;
    busy_mid     = 1'b0;
    tx_ready_mid = 1'b0;
    tick(2);
    check_reset("por");
    reset = 1'b0;
    tick(6);

    // Reset in the middle of a frame, then a fresh frame once ss has cycled high.
    spi_frame(8'hE7, 3, 1'b0, 1'b0);
    check("midframe_busy", busy, 1'b1);
    reset = 1'b1;
    tick(2);
    check_reset("mid_reset");
    reset = 1'b0;
    tick(8);
    check("ss_low_ignored_busy", busy, 1'b0);
    ss = 1'b1;
    tick(6);
    exp_q.push_back(8'hC3);
    spi_frame(8'hC3, 8, 1'b1, 1'b0);
    check("c3_frame_miso", miso_byte, 8'h00);
    drain_one("rx_c3");

    // Preloaded TX byte returned while a byte is received.
    load_tx(8'hA5);
    check("tx_ready_after_load", tx_ready, 1'b0);
    exp_q.push_back(8'h3C);
    spi_frame(8'h3C, 8, 1'b1, 1'b0);
    check("a5_miso", miso_byte, 8'hA5);
    check("busy_mid_frame", busy_mid, 1'b1);
    check("tx_ready_mid_frame", tx_ready_mid, 1'b1);
    check("busy_after_frame", busy, 1'b0);
    drain_one("rx_3c");
    check("rx_valid_after_pop", rx_valid, 1'b0);

    // Second load while the holding register is full must be ignored.
    load_tx(8'h5A);
    load_tx(8'hFF);
    exp_q.push_back(8'h96);
    spi_frame(8'h96, 8, 1'b1, 1'b0);
    check("ignored_load_miso", miso_byte, 8'h5A);
    drain_one("rx_96");

    // Two frames with rx_ready held low.
    exp_q.push_back(8'h11);
    spi_frame(8'h11, 8, 1'b1, 1'b0);
    check("no_load_miso", miso_byte, 8'h00);
`ifdef SPI_SLAVE_RX_FIFO_EN
    exp_q.push_back(8'h22);
`endif
    spi_frame(8'h22, 8, 1'b1, 1'b0);
    tick(4);
`ifdef SPI_SLAVE_RX_FIFO_EN
    check("two_frames_overrun", overrun, 1'b0);
    drain_one("rx_11");
    drain_one("rx_22");
`else
    check("two_frames_overrun", overrun, 1'b1);
    drain_one("rx_11");
`endif
    check("rx_valid_after_two", rx_valid, 1'b0);

    // Aborted frame after five bits, then a clean frame.
    spi_frame(8'h5A, 5, 1'b1, 1'b0);
    check("abort_rx_valid", rx_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    exp_q.push_back(8'h81);
    spi_frame(8'h81, 8, 1'b1, 1'b0);
    drain_one("rx_81");

`ifdef SPI_SLAVE_RX_FIFO_EN
    // Five frames into a four-entry FIFO with no consumer.
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp_q.push_back(8'(v));
      spi_frame(8'(v), 8, 1'b1, 1'b0);
    end
    check("fifo_full_overrun", overrun, 1'b1);
    for (int k = 0; k < 4; k++) drain_one("fifo_drain");
    check("fifo_empty_after_drain", rx_valid, 1'b0);

    // Full FIFO with a pop landing on the push cycle: no overrun, order kept.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(6);
    for (int v = 16; v < 20; v++) begin
      exp_q.push_back(8'(v));
      spi_frame(8'(v), 8, 1'b1, 1'b0);
    end
    check("prefill_overrun", overrun, 1'b0);
    exp_q.push_back(8'h14);
    spi_frame(8'h14, 8, 1'b1, 1'b1);
    check("full_pop_push_overrun", overrun, 1'b0);
    for (int k = 0; k < 4; k++) drain_one("full_pop_drain");
    check("full_pop_empty", rx_valid, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

Byte-oriented SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first. It sits directly downstream of the SPI master on the shared SCLK/MOSI/MISO/SS lines. It oversamples the SPI lines on its own system clock and presents each received byte on a valid/ready stream. It returns a preloaded transmit byte on MISO during the same frame.

## Interface
- DATA_W, 8, frame width in bits
- SYNC_STAGES, 2, synchronizer flops on sclk/mosi/ss (min 2)
- FIFO_DEPTH, 4, RX FIFO entries; power of two; used only with SPI_SLAVE_RX_FIFO_EN

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sclk  in  1  SPI clock from master (asynchronous to clk)
- mosi  in  1  master-out data
- ss  in  1  slave select, active low
- miso  out  1  slave-out data
- tx_data  in  DATA_W  byte to return in next frame
- tx_load  in  1  write strobe for tx_data
- tx_ready  out  1  TX holding register empty
- rx_data  out  DATA_W  received byte
- rx_valid  out  1  rx_data valid
- rx_ready  in  1  consumer accepts rx_data
- overrun  out  1  sticky: a received byte was dropped
- busy  out  1  frame in progress

## Operation
- Reset values: miso=0, tx_ready=1, rx_data=0, rx_valid=0, overrun=0, busy=0, state=IDLE, bit counter=0, TX holding register=0.
- sclk, mosi and ss each pass through SYNC_STAGES flops. Edges are detected by comparing the last sync stage with a one-cycle-delayed copy.
- FSM states:
  - IDLE: ss_sync high. On an ss_sync falling edge: copy the holding register into the TX shift register, drive miso with its MSB, clear the bit counter, set busy, set tx_ready=1, then go to ACTIVE.
  - ACTIVE, on an sclk_sync rising edge: shift mosi_sync into the RX shift register LSB and increment the bit counter.
  - ACTIVE, on an sclk_sync falling edge: shift the TX register left and drive miso with the new MSB.
  - ACTIVE, after DATA_W rising edges: go to COMPLETE.
  - ACTIVE, on an ss_sync rising edge before DATA_W bits: abort, discard the partial byte, no RX push, go to IDLE.
  - COMPLETE (1 cycle): push the RX byte, then go to WAIT.
  - WAIT: ignore further sclk edges. On an ss_sync rising edge go to IDLE and clear busy.
- TX loading:
  - tx_load while tx_ready=1 latches tx_data and clears tx_ready.
  - tx_load while tx_ready=0 is ignored.
  - If no byte is loaded at frame start, the frame transmits 0x00.
  - tx_load in the same cycle as frame start goes to the next frame.
- RX output (macro off): single output register.
  - A push while the register is empty, or while rx_valid&&rx_ready, loads it.
  - A push otherwise drops the new byte and sets overrun.
  - rx_valid clears on rx_ready when no push occurs in that cycle.
- overrun clears only on reset.
- reset asserted mid-frame aborts immediately. After reset the FSM waits in IDLE for a fresh ss falling edge; an ss that is already low is ignored until it goes high.

## Timing
- SCLK high and low phases must each be ≥ SYNC_STAGES+1 clk periods. SS setup to the first SCLK rise must also be ≥ SYNC_STAGES+1 clk periods.
- First MISO bit is valid SYNC_STAGES+1 clk edges after the SS pin falls. Each next bit is valid SYNC_STAGES+1 edges after the SCLK pin falls.
- rx_valid rises SYNC_STAGES+2 clk edges after the DATA_W-th SCLK rising edge at the pin.
- The rx handshake completes on the clk edge where rx_valid && rx_ready.
- tx_ready rises in the cycle the frame-start copy occurs.

## Configuration
- SPI_SLAVE_RX_FIFO_EN defined:
  - Received bytes go into a FIFO_DEPTH-entry RX FIFO.
  - rx_valid = !empty; rx_data = head entry (first-word fall-through).
  - A push while full sets overrun and drops the byte.
  - Simultaneous push and pop while full succeeds, with no overrun.
- Undefined: single output register as described in Operation.

## Test plan
- Reset mid-frame (ss low, 3 bits shifted) -> all outputs return to reset values. A following full frame with 0xC3 yields rx_data=0xC3.
- tx_load 0xA5, then master sends 0x3C with SCLK phases of 4 clk -> master samples 0xA5 on MISO; rx_data=0x3C with rx_valid; tx_ready=1 after frame start.
- Frame with no tx_load -> MISO carries 0x00. rx_ready held low across two frames (0x11, 0x22) -> macro off: rx_data=0x11 and overrun=1; macro on: 0x11 then 0x22 both delivered, overrun=0.
- ss raised after 5 SCLK rising edges -> no rx_valid, busy=0. The next full frame 0x81 is received correctly.
- Macro on, rx_ready=0: send 5 frames 0x01..0x05 -> 4 bytes held and overrun=1. Then drain -> 0x01..0x04 in order.
- Macro on, FIFO full with rx_ready=1 in the exact cycle of the COMPLETE push -> no overrun, order preserved.
